plab1_imul_int_div_iterative: RTL and testbench
===============================================

# plab1_imul_int_div_iterative

Iterative 32-bit integer divider; the inverse unit of the variable-latency multiplier, sharing its MulDiv request message format and val/rdy stream interface. It serves the `div`, `divu`, `rem` and `remu` funcs of a MulDiv request and completes each request in a fixed number of cycles. Datapath and control are security-labelled by `domain`; all data and handshake signals carry label `{Domain domain}`.

## Interface
Parameters:
- none; widths come from the shared MulDiv message constants: func 3, a 32, b 32, request 67 bits.

Ports:
- clk  in  1  clock, label `{L}`.
- reset  in  1  synchronous, active-high, label `{L}`.
- domain  in  1  security domain of the current transaction, label `{L}`.
- in_val  in  1  request valid.
- in_rdy  out  1  request ready.
- in_msg  in  67  request as {func, a, b}; func occupies the top 3 bits.
- out_val  out  1  response valid.
- out_rdy  in  1  response ready.
- out_msg  out  32  quotient or remainder.

## Operation
- Func encodings: mul=0, div=1, divu=2, rem=3, remu=4. Funcs 0, 5, 6 and 7 execute as divu.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_go (in_val && in_rdy), latch:
    - the func;
    - sign_a = signed func && a[31];
    - sign_b = signed func && b[31];
    - div_zero = (b==0).
  - Load the 64-bit {rem_hi, quo_lo} register with {32'b0, |a|}.
  - Load the divisor register with |b|. Magnitudes apply to signed funcs only; |0x80000000| = 0x80000000 unsigned.
  - Counter=32. Go to CALC.
- CALC, once per cycle (restoring algorithm):
  - Shift {rem_hi, quo_lo} left by 1.
  - Compute the 33-bit diff = {0, rem_hi} − {0, divisor}.
  - If diff[32]==0, set rem_hi=diff[31:0] and quo_lo[0]=1.
  - Decrement the counter. When the counter reaches 1 this cycle, go to DONE.
- DONE:
  - out_val=1, in_rdy=0.
  - out_msg is the registered result. The fixup is applied at the CALC→DONE transition:
    - quotient = (sign_a^sign_b) ? −quo_lo : quo_lo;
    - remainder = sign_a ? −rem_hi : rem_hi;
    - if div_zero: quotient=0xFFFFFFFF, remainder=original a.
  - div/divu select the quotient; rem/remu select the remainder.
  - On out_go, go to IDLE.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives 0x80000000, and rem gives 0. This needs no special case.
- Reset: state→IDLE, result register→0, counter→0. in_rdy=0 and out_val=0 while reset is high.

## Timing
- Request accepted at edge T → CALC during T+1..T+32 → out_val=1 from T+33.
- Earliest next acceptance is T+34 with out_rdy=1; throughput is 1 request per 34 cycles.
- in_rdy is asserted only in IDLE; there is no combinational path in_val→in_rdy or out_rdy→in_rdy.
- With out_rdy=0 in DONE, out_val stays 1 and out_msg is stable until out_go.
- Reset asserted mid-CALC or in DONE aborts the transaction. out_val=0 on the cycle after the reset edge; the partial result is discarded.
- Latency is data-independent: 32 CALC cycles for all operands, including b==0. No timing channel on operands.

## Structure
- Func encodings and field widths/offsets go in the shared MulDiv message include, alongside the existing pack/unpack modules. Unpack is done via the existing request unpack module.
- Split into plab1_imul_IntDivIterDpath (operand registers, 33-bit subtractor, negators, result mux/register) and plab1_imul_IntDivIterCtrl (FSM, 6-bit counter, control table).
- The ctrl→dpath signals are:
  - load;
  - shift_en;
  - result_en;
  - sel_rem.
- The dpath→ctrl signal is count_done, or the counter is kept in ctrl.
- Reuse the shared library muxes, registers, subtractor and enable-register cells.

## Test plan
- divu a=100, b=7 → 14. remu same operands → 2. Response out_val exactly 33 cycles after acceptance.
- div a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD. rem same operands → 0xFFFFFFFF.
- div 5/0 → 0xFFFFFFFF; rem 5/0 → 5; divu 0xFFFFFFFF/0 → 0xFFFFFFFF. All with 33-cycle latency.
- div 0x80000000 / 0xFFFFFFFF → 0x80000000; rem same operands → 0.
- Hold out_rdy=0 for 10 cycles in DONE → out_val=1, out_msg constant, in_rdy=0, and a second in_val is not accepted. Release → next request accepted the cycle after out_go.
- Assert reset at CALC cycle 15 → out_val=0, in_rdy=1 after reset drops. New request divu 9/3 → 3 with normal latency.

Source files
------------

// File: rtl/plab1_imul_int_div_iterative_pkg.sv
// Shared MulDiv request format, func encodings and divider FSM states.
// Funcs other than div/rem/remu fall through to unsigned divide.
package plab1_imul_int_div_iterative_pkg;

  localparam int FUNC_W   = 3;
  localparam int A_W      = 32;
  localparam int B_W      = 32;
  localparam int REQ_W    = FUNC_W + A_W + B_W;
  localparam int B_LSB    = 0;
  localparam int A_LSB    = B_W;
  localparam int FUNC_LSB = A_W + B_W;

  localparam logic [2:0] FUNC_MUL  = 3'd0;
  localparam logic [2:0] FUNC_DIV  = 3'd1;
  localparam logic [2:0] FUNC_DIVU = 3'd2;
  localparam logic [2:0] FUNC_REM  = 3'd3;
  localparam logic [2:0] FUNC_REMU = 3'd4;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [A_W-1:0]    a;
    logic [B_W-1:0]    b;
  } muldiv_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic muldiv_req_t unpack_req(input logic [REQ_W-1:0] msg);
    return muldiv_req_t'(msg);
  endfunction

  function automatic logic is_signed_func(input logic [2:0] f);
    return (f == FUNC_DIV) || (f == FUNC_REM);
  endfunction

  function automatic logic is_rem_func(input logic [2:0] f);
    return (f == FUNC_REM) || (f == FUNC_REMU);
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/plab1_imul_int_div_iterative_ctrl.sv
// Divider control: IDLE/CALC/DONE FSM with a 6-bit step counter.
// Handshake outputs decode only state and reset, never in_val or out_rdy.
module plab1_imul_IntDivIterCtrl
  import plab1_imul_int_div_iterative_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  input  logic       out_rdy,
  input  logic [2:0] req_func,
  output logic       in_rdy,
  output logic       out_val,
  output logic       load,
  output logic       shift_en,
  output logic       result_en,
  output logic       sel_rem
);

  div_state_e  state_r, next_state_s;
  logic [5:0]  count_r;
  logic [2:0]  func_r;
  logic        in_rdy_s, out_val_s, load_s, shift_en_s, result_en_s;

  // Next-state and control table.
  always_comb begin
    next_state_s = state_r;
    in_rdy_s     = 1'b0;
    out_val_s    = 1'b0;
    load_s       = 1'b0;
    shift_en_s   = 1'b0;
    result_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_rdy_s = !reset;
        load_s   = in_val && !reset;
        if (load_s) next_state_s = ST_CALC;
        else        next_state_s = ST_IDLE;
      end
      ST_CALC: begin
        shift_en_s = 1'b1;
        if (count_r == 6'd1) begin
          result_en_s  = 1'b1;
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        out_val_s = !reset;
        if (out_rdy) next_state_s = ST_IDLE;
        else         next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, step counter and latched func.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= 6'd0;
      func_r  <= 3'd0;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        count_r <= 6'd32;
        func_r  <= req_func;
      end else if (shift_en_s) begin
        count_r <= count_r - 6'd1;
      end
    end
  end

  assign in_rdy    = in_rdy_s;
  assign out_val   = out_val_s;
  assign load      = load_s;
  assign shift_en  = shift_en_s;
  assign result_en = result_en_s;
  assign sel_rem   = is_rem_func(func_r);

endmodule

// File: rtl/plab1_imul_int_div_iterative_dpath.sv
// Divider datapath: operand/remainder registers, 33-bit restoring subtractor,
// sign fixup negators and the registered result.
module plab1_imul_IntDivIterDpath
  import plab1_imul_int_div_iterative_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift_en,
  input  logic        result_en,
  input  logic        sel_rem,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] result
);

  logic [31:0] rem_hi_r, quo_lo_r, divisor_r, result_r;
  logic        sign_a_r, sign_b_r, div_zero_r;
  logic        sign_a_s, sign_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [63:0] shifted_s;
  logic [32:0] diff_s;
  logic [31:0] next_rem_s, next_quo_s, quo_fix_s, rem_fix_s;

  // Operand magnitudes, one restoring step and the sign/div-by-zero fixup.
  always_comb begin
    sign_a_s  = is_signed_func(req_func) && req_a[31];
    sign_b_s  = is_signed_func(req_func) && req_b[31];
    mag_a_s   = sign_a_s ? neg32(req_a) : req_a;
    mag_b_s   = sign_b_s ? neg32(req_b) : req_b;
    shifted_s = {rem_hi_r[30:0], quo_lo_r, 1'b0};
    diff_s    = {1'b0, shifted_s[63:32]} - {1'b0, divisor_r};
    if (diff_s[32]) begin
      next_rem_s = shifted_s[63:32];
      next_quo_s = shifted_s[31:0];
    end else begin
      next_rem_s = diff_s[31:0];
      next_quo_s = {shifted_s[31:1], 1'b1};
    end
    // With b==0 every step succeeds, so the remainder path already rebuilds a.
    rem_fix_s = sign_a_r ? neg32(next_rem_s) : next_rem_s;
    if (div_zero_r) begin
      quo_fix_s = 32'hFFFF_FFFF;
    end else begin
      quo_fix_s = (sign_a_r ^ sign_b_r) ? neg32(next_quo_s) : next_quo_s;
    end
  end

  // Operand latch on accept, then one shift/subtract step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_hi_r   <= 32'd0;
      quo_lo_r   <= 32'd0;
      divisor_r  <= 32'd0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (load) begin
      rem_hi_r   <= 32'd0;
      quo_lo_r   <= mag_a_s;
      divisor_r  <= mag_b_s;
      sign_a_r   <= sign_a_s;
      sign_b_r   <= sign_b_s;
      div_zero_r <= (req_b == 32'd0);
    end else if (shift_en) begin
      rem_hi_r   <= next_rem_s;
      quo_lo_r   <= next_quo_s;
    end
  end

  // Result register captures the fixed-up answer on the final CALC step.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= 32'd0;
    end else if (result_en) begin
      result_r <= sel_rem ? rem_fix_s : quo_fix_s;
    end
  end

  assign result = result_r;

endmodule

// File: rtl/plab1_imul_int_div_iterative.sv
// Iterative 32-bit divider serving div/divu/rem/remu with fixed 32-step latency.
module plab1_imul_int_div_iterative
  import plab1_imul_int_div_iterative_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             domain,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [REQ_W-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [31:0]      out_msg
);

  muldiv_req_t req_s;
  logic        load_s, shift_en_s, result_en_s, sel_rem_s;
  logic        unused_domain_s;

  assign req_s = unpack_req(in_msg);
  // The label only tags the transaction; no datapath decision depends on it.
  assign unused_domain_s = domain;

  plab1_imul_IntDivIterCtrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .out_rdy   (out_rdy),
    .req_func  (req_s.func),
    .in_rdy    (in_rdy),
    .out_val   (out_val),
    .load      (load_s),
    .shift_en  (shift_en_s),
    .result_en (result_en_s),
    .sel_rem   (sel_rem_s)
  );

  plab1_imul_IntDivIterDpath u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .shift_en  (shift_en_s),
    .result_en (result_en_s),
    .sel_rem   (sel_rem_s),
    .req_func  (req_s.func),
    .req_a     (req_s.a),
    .req_b     (req_s.b),
    .result    (out_msg)
  );

endmodule

// File: tb/tb_plab1_imul_int_div_iterative.sv
// Self-checking bench for the iterative divider: scoreboard of expected
// responses, fixed 33-cycle latency, backpressure and mid-calc reset.
module tb_plab1_imul_int_div_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        domain;
  logic        in_val;
  logic        in_rdy;
  logic [66:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  plab1_imul_int_div_iterative dut (
    .clk     (clk),
    .reset   (reset),
    .domain  (domain),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (f)
      3'd1: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'd3: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      3'd4: r = (b == 32'd0) ? a : a % b;
      default: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
    return r;
  endfunction

  // Drives one request with out_rdy=1; returns response and acceptance-to-out_val cycles.
  task automatic run_txn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] msg, output int cyc);
    int n;
    in_msg = {f, a, b};
    in_val = 1'b1;
    out_rdy = 1'b1;
    n = 0;
    while (!in_rdy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    cyc = 1;
    while (!out_val && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    msg = out_msg;
    if (out_val) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b1; out_rdy = 1'b1; domain = 1'b0;
    in_msg = {3'd2, 32'd100, 32'd7};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_rdy !== 1'b0 || out_val !== 1'b0 || out_msg !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold got rdy=%b val=%b msg=%h expected 0 0 00000000", in_rdy, out_val, out_msg);
    end
    in_val = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b val=%b expected 1 0", in_rdy, out_val);
    end
  endtask

  task automatic test_divide();
    vec_t v[11] = '{
      '{3'd2, 32'd100,        32'd7,        32'd14},
      '{3'd4, 32'd100,        32'd7,        32'd2},
      '{3'd1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD},
      '{3'd3, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF},
      '{3'd1, 32'd5,          32'd0,        32'hFFFF_FFFF},
      '{3'd3, 32'd5,          32'd0,        32'd5},
      '{3'd2, 32'hFFFF_FFFF,  32'd0,        32'hFFFF_FFFF},
      '{3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
      '{3'd0, 32'd100,        32'd7,        32'd14},
      '{3'd6, 32'hFFFF_FFF9,  32'd2,        32'h7FFF_FFFC}
    };
    logic [31:0] msg, exp;
    int cyc;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(v[i].e);
      run_txn(v[i].f, v[i].a, v[i].b, msg, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (msg !== exp) begin
        errors++;
        $display("FAIL divide[%0d] func=%0d got %h expected %h", i, v[i].f, msg, exp);
      end
      checks++;
      if (cyc != 33) begin
        errors++;
        $display("FAIL latency[%0d] got %0d expected 33", i, cyc);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] msg, exp;
    int cyc;
    exp_q.push_back(32'd33);
    run_txn(3'd2, 32'd1000, 32'd30, msg, cyc);
    exp = exp_q.pop_front();
    checks++;
    if (msg !== exp) begin
      errors++;
      $display("FAIL b2b_first got %h expected %h", msg, exp);
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rdy_after_go got %b expected 1", in_rdy);
    end
    exp_q.push_back(32'd10);
    run_txn(3'd4, 32'd1000, 32'd30, msg, cyc);
    exp = exp_q.pop_front();
    checks++;
    if (msg !== exp || cyc != 33) begin
      errors++;
      $display("FAIL b2b_second got %h/%0d expected %h/33", msg, cyc, exp);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int n;
    exp_q.push_back(32'd100);
    in_msg = {3'd2, 32'd1000, 32'd10};
    in_val = 1'b1; out_rdy = 1'b0;
    @(posedge clk); #1;
    in_msg = {3'd4, 32'd1000, 32'd7};
    n = 0;
    while (!out_val && n < 200) begin
      @(posedge clk); #1; n++;
    end
    exp = exp_q.pop_front();
    exp_q.push_back(32'd6);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_val !== 1'b1 || out_msg !== exp || in_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got val=%b msg=%h rdy=%b expected 1 %h 0", i, out_val, out_msg, in_rdy, exp);
      end
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL after_out_go got rdy=%b val=%b expected 1 0", in_rdy, out_val);
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    n = 1;
    while (!out_val && n < 200) begin
      @(posedge clk); #1; n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_msg !== exp || n != 33) begin
      errors++;
      $display("FAIL bp_second got %h/%0d expected %h/33", out_msg, n, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] msg, exp;
    int cyc;
    in_msg = {3'd2, 32'd1000, 32'd10};
    in_val = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (in_rdy !== 1'b0 || out_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold got rdy=%b val=%b expected 0 0", in_rdy, out_val);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0 || out_msg !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_after got rdy=%b val=%b msg=%h expected 1 0 00000000", in_rdy, out_val, out_msg);
    end
    exp_q.push_back(32'd3);
    run_txn(3'd2, 32'd9, 32'd3, msg, cyc);
    exp = exp_q.pop_front();
    checks++;
    if (msg !== exp || cyc != 33) begin
      errors++;
      $display("FAIL reset_mid_next got %h/%0d expected %h/33", msg, cyc, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, msg, exp;
    logic [2:0]  f;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      domain = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_model(f, a, b));
      run_txn(f, a, b, msg, cyc);
      exp = exp_q.pop_front();
      checks++;
      if (msg !== exp || cyc != 33) begin
        errors++;
        $display("FAIL random[%0d] f=%0d a=%h b=%h got %h/%0d expected %h/33", i, f, a, b, msg, cyc, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
